// File: rtl/sopc_inst_mem.sv
// rtl/sopc_inst_mem.sv - wait-stated instruction memory with one-entry fetch buffer
// Sits between the CPU IF port and a synchronous word array; stalls IF on a buffer miss.
module sopc_inst_mem #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_LOG2  = 10,
    parameter int                    WAIT_STATES = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_ce_i,
    input  logic [ADDR_WIDTH-1:0] rom_addr_i,
    output logic [DATA_WIDTH-1:0] rom_data_o,
    output logic                  rom_valid_o,
    output logic                  stall_req_o,
    output logic                  addr_err_o,
    input  logic                  prog_we_i,
    input  logic [DEPTH_LOG2-1:0] prog_addr_i,
    input  logic [DATA_WIDTH-1:0] prog_data_i,
    output logic [15:0]           fetch_cnt_o
);
    localparam int         WORDS   = 1 << DEPTH_LOG2;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_mem [0:WORDS-1];
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_tag, r_req;
    logic                  r_vld, r_err;
    logic [3:0]            r_cnt;
    logic [15:0]           r_fetch_cnt;

    logic                  w_borrow;
    logic [ADDR_WIDTH-1:0] w_off, w_req_off, w_tag_off;
    logic [DEPTH_LOG2-1:0] w_req_idx, w_tag_idx;
    logic                  w_bad, w_abort, w_prog_hit_req, w_prog_hit_tag;
    logic                  w_start, w_err_fill, w_fill;

    // A borrow out of the subtraction flags addresses below the base.
    assign {w_borrow, w_off} = {1'b0, rom_addr_i} - {1'b0, BASE_ADDR};
    assign w_req_off = r_req - BASE_ADDR;
    assign w_tag_off = r_tag - BASE_ADDR;
    assign w_req_idx = w_req_off[DEPTH_LOG2+1:2];
    assign w_tag_idx = w_tag_off[DEPTH_LOG2+1:2];

    assign w_bad = w_borrow
                 | (w_off[ADDR_WIDTH-1:DEPTH_LOG2+2] != '0)
                 | (rom_addr_i[1:0] != 2'b00);

    assign rom_valid_o = rom_ce_i & r_vld & (r_tag == rom_addr_i);
    assign stall_req_o = rom_ce_i & ~rom_valid_o;
    assign rom_data_o  = rom_valid_o ? r_data : '0;
    assign addr_err_o  = rom_valid_o & r_err;
    assign fetch_cnt_o = r_fetch_cnt;

    assign w_abort        = ~rom_ce_i | (rom_addr_i != r_req);
    assign w_prog_hit_req = prog_we_i & (prog_addr_i == w_req_idx);
    assign w_prog_hit_tag = prog_we_i & (prog_addr_i == w_tag_idx);

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_err_fill = 1'b0;
        w_fill     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (stall_req_o) begin
                    if (w_bad) begin
                        w_err_fill = 1'b1;
                    end else begin
                        w_start = 1'b1;
                        w_next  = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (!w_prog_hit_req && r_cnt == 4'd0) begin
                    w_fill = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (prog_we_i) begin
            r_mem[prog_addr_i] <= prog_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_data      <= '0;
            r_tag       <= '0;
            r_vld       <= 1'b0;
            r_err       <= 1'b0;
            r_req       <= '0;
            r_cnt       <= 4'd0;
            r_fetch_cnt <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_req <= rom_addr_i;
                r_cnt <= WS_LOAD;
            end else if (r_state == S_BUSY && !w_abort) begin
                // Rewriting the word being fetched restarts the wait so the new data is returned.
                if (w_prog_hit_req) begin
                    r_cnt <= WS_LOAD;
                end else if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
            if (w_prog_hit_tag) begin
                r_vld <= 1'b0;
            end
            if (w_err_fill) begin
                r_data <= '0;
                r_tag  <= rom_addr_i;
                r_vld  <= 1'b1;
                r_err  <= 1'b1;
            end
            if (w_fill) begin
                r_data <= r_mem[w_req_idx];
                r_tag  <= r_req;
                r_vld  <= 1'b1;
                r_err  <= 1'b0;
                if (r_fetch_cnt != 16'hFFFF) begin
                    r_fetch_cnt <= r_fetch_cnt + 16'd1;
                end
            end
        end
    end
endmodule
